// File: rtl/seg7_message_sequencer.sv
// Message sequencer feeding seg7_control: steps a 4-entry character ROM on a ms-based dwell
// timer (AUTO) or holds it (HOLD), with debounced next/pause push buttons.
module seg7_message_sequencer #(
  parameter int TICK_DIV     = 50_000,
  parameter int DWELL_TICKS  = 1000,
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic        clk_50MHz,
  input  logic        reset_button,
  input  logic        btn_next,
  input  logic        btn_pause,
  output logic [15:0] bcd,
  output logic [1:0]  msg_index,
  output logic        msg_strobe,
  output logic        paused
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DWELL_TICKS + 1);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  typedef enum logic {AUTO = 1'b0, HOLD = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [DW-1:0]       dwell_q, dwell_d;
  logic [1:0]          msg_index_q, msg_index_d;
  logic [15:0]         bcd_q, bcd_d;
  logic                msg_strobe_q, msg_strobe_d;
  logic [1:0]          sync1_q, sync1_d;
  logic [1:0]          sync2_q, sync2_d;
  logic [1:0]          db_q, db_d;
  logic [1:0][CW-1:0]  deb_cnt_q, deb_cnt_d;

  logic [1:0] press;
  logic       ms_tick;
  logic       expire;
  logic       step;

  function automatic logic [15:0] rom_word(input logic [1:0] idx);
    logic [15:0] w;
    case (idx)
      2'd0:    w = 16'h0231;
      2'd1:    w = 16'h055F;
      2'd2:    w = 16'h443F;
      default: w = 16'h4444;
    endcase
    return w;
  endfunction

  // Bit 0 is btn_next, bit 1 is btn_pause; an accepted rising level yields a one-cycle press.
  always_comb begin
    sync1_d   = {btn_pause, btn_next};
    sync2_d   = sync1_q;
    db_d      = db_q;
    deb_cnt_d = '0;
    press     = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (deb_cnt_q[i] == CW'(DEBOUNCE_CYC - 1)) begin
          db_d[i]  = sync2_q[i];
          press[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    ms_tick    = (tick_cnt_q == TW'(TICK_DIV - 1));
    tick_cnt_d = ms_tick ? '0 : tick_cnt_q + 1'b1;
    expire     = (state_q == AUTO) && ms_tick && (dwell_q == DW'(DWELL_TICKS - 1));

    dwell_d = dwell_q;
    if ((state_q == AUTO) && ms_tick) begin
      dwell_d = expire ? '0 : dwell_q + 1'b1;
    end
    // A next press restarts the dwell even when it coincides with expiry: still one step.
    if (press[0]) begin
      dwell_d = '0;
    end

    step = expire | press[0];

    state_d = state_q;
    if (press[1]) begin
      state_d = (state_q == AUTO) ? HOLD : AUTO;
    end

    msg_index_d  = msg_index_q + {1'b0, step};
    bcd_d        = rom_word(msg_index_d);
    msg_strobe_d = step;
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset_button) begin
      state_q      <= AUTO;
      tick_cnt_q   <= '0;
      dwell_q      <= '0;
      msg_index_q  <= 2'd0;
      bcd_q        <= 16'h0231;
      msg_strobe_q <= 1'b0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      db_q         <= '0;
      deb_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      dwell_q      <= dwell_d;
      msg_index_q  <= msg_index_d;
      bcd_q        <= bcd_d;
      msg_strobe_q <= msg_strobe_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      db_q         <= db_d;
      deb_cnt_q    <= deb_cnt_d;
    end
  end

  assign bcd        = bcd_q;
  assign msg_index  = msg_index_q;
  assign msg_strobe = msg_strobe_q;
  assign paused     = (state_q == HOLD);

endmodule

// File: tb/tb_seg7_message_sequencer.sv
// Bench for seg7_message_sequencer: directed scenarios plus random button traffic, all checked
// against a timeline model built from the message/dwell/debounce rules.
module tb_seg7_message_sequencer;

  localparam int M_TICK  = 4;
  localparam int M_DWELL = 3;
  localparam int M_DEB   = 2;

  logic        clk_50MHz;
  logic        reset_button;
  logic        btn_next;
  logic        btn_pause;
  logic [15:0] bcd;
  logic [1:0]  msg_index;
  logic        msg_strobe;
  logic        paused;

  int compared;
  int mismatched;
  int strobeSeen;

  // Model state: cycles since reset, ticks left in current dwell, message and mode.
  int m_cyc;
  int m_rem;
  int m_idx;
  bit m_paused;
  bit m_strobe;
  bit pipe[2][2];
  bit win[2][M_DEB];
  int wfill[2];
  bit db[2];

  seg7_message_sequencer #(
    .TICK_DIV    (M_TICK),
    .DWELL_TICKS (M_DWELL),
    .DEBOUNCE_CYC(M_DEB)
  ) dut (
    .clk_50MHz   (clk_50MHz),
    .reset_button(reset_button),
    .btn_next    (btn_next),
    .btn_pause   (btn_pause),
    .bcd         (bcd),
    .msg_index   (msg_index),
    .msg_strobe  (msg_strobe),
    .paused      (paused)
  );

  initial clk_50MHz = 1'b0;
  always #5 clk_50MHz = ~clk_50MHz;

  function automatic logic [15:0] romText(input int idx);
    logic [15:0] w;
    case (idx)
      0:       w = 16'h0231;
      1:       w = 16'h055F;
      2:       w = 16'h443F;
      default: w = 16'h4444;
    endcase
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_cyc    = 0;
    m_rem    = M_DWELL;
    m_idx    = 0;
    m_paused = 1'b0;
    m_strobe = 1'b0;
    for (int b = 0; b < 2; b++) begin
      pipe[b][0] = 1'b0;
      pipe[b][1] = 1'b0;
      wfill[b]   = 0;
      db[b]      = 1'b0;
    end
  endtask

  // A level is accepted once the last M_DEB synchronised samples all differ from the accepted one.
  task automatic debStep(input int b, input bit raw, output bit evt);
    bit s;
    bit allDiffer;
    evt = 1'b0;
    s = pipe[b][0];
    pipe[b][0] = pipe[b][1];
    pipe[b][1] = raw;
    for (int k = 0; k < M_DEB - 1; k++) win[b][k] = win[b][k+1];
    win[b][M_DEB-1] = s;
    if (wfill[b] < M_DEB) wfill[b]++;
    allDiffer = (wfill[b] == M_DEB);
    for (int k = 0; k < M_DEB; k++) if (win[b][k] == db[b]) allDiffer = 1'b0;
    if (allDiffer) begin
      db[b]    = s;
      evt      = s;
      wfill[b] = 0;
    end
  endtask

  task automatic modelStep(input bit n, input bit p, input bit r);
    bit en;
    bit ep;
    bit expire;
    if (r) begin
      modelReset();
    end else begin
      debStep(0, n, en);
      debStep(1, p, ep);
      expire = 1'b0;
      if (!m_paused && (m_cyc % M_TICK == M_TICK - 1)) begin
        m_rem--;
        if (m_rem == 0) expire = 1'b1;
      end
      m_cyc++;
      if (expire || en) begin
        m_rem    = M_DWELL;
        m_idx    = (m_idx + 1) % 4;
        m_strobe = 1'b1;
      end else begin
        m_strobe = 1'b0;
      end
      if (ep) m_paused = !m_paused;
    end
  endtask

  task automatic applyStimulus(input bit n, input bit p, input bit r);
    @(negedge clk_50MHz);
    btn_next     = n;
    btn_pause    = p;
    reset_button = r;
    @(posedge clk_50MHz);
    modelStep(n, p, r);
    #1;
    if (msg_strobe === 1'b1) strobeSeen++;
    checkOutput("bcd", 32'(bcd), 32'(romText(m_idx)));
    checkOutput("msg_index", 32'(msg_index), 32'(m_idx));
    checkOutput("msg_strobe", 32'(msg_strobe), 32'(m_strobe));
    checkOutput("paused", 32'(paused), 32'(m_paused));
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int lat;
    bit n;
    bit p;
    compared     = 0;
    mismatched   = 0;
    strobeSeen   = 0;
    btn_next     = 1'b0;
    btn_pause    = 1'b0;
    reset_button = 1'b1;
    modelReset();

    // Reset state and the free-running AUTO rotation.
    doReset();
    checkOutput("reset_idx", 32'(msg_index), 32'd0);
    checkOutput("reset_bcd", 32'(bcd), 32'h0231);
    checkOutput("reset_strobe", 32'(msg_strobe), 32'd0);
    checkOutput("reset_paused", 32'(paused), 32'd0);
    strobeSeen = 0;
    idle(11);
    checkOutput("no_strobe_before_12", 32'(strobeSeen), 32'd0);
    idle(1);
    checkOutput("first_step_idx", 32'(msg_index), 32'd1);
    checkOutput("first_step_bcd", 32'(bcd), 32'h055F);
    checkOutput("first_step_strobe", 32'(msg_strobe), 32'd1);
    idle(36);
    checkOutput("wrap_strobes", 32'(strobeSeen), 32'd4);
    checkOutput("wrap_idx", 32'(msg_index), 32'd0);
    checkOutput("wrap_bcd", 32'(bcd), 32'h0231);

    // Short glitch is rejected; a held press steps once and restarts the dwell.
    doReset();
    strobeSeen = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(5);
    checkOutput("glitch_no_step", 32'(strobeSeen), 32'd0);
    lat = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      if (strobeSeen == 0) lat++;
    end
    checkOutput("next_latency_ok", 32'((lat + 1 >= 4) && (lat + 1 <= 6)), 32'd1);
    idle(6);
    checkOutput("next_single_step", 32'(strobeSeen), 32'd1);
    checkOutput("next_idx", 32'(msg_index), 32'd1);

    // Pause freezes the rotation; a second press resumes from the frozen count.
    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    strobeSeen = 0;
    idle(100);
    checkOutput("hold_no_strobes", 32'(strobeSeen), 32'd0);
    checkOutput("hold_paused", 32'(paused), 32'd1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("resume_paused", 32'(paused), 32'd0);
    idle(12);
    checkOutput("resume_stepped", 32'(strobeSeen), 32'd1);

    // Next press accepted on the dwell-expiry cycle gives a single step.
    doReset();
    strobeSeen = 0;
    idle(8);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    idle(7);
    checkOutput("coincident_strobes", 32'(strobeSeen), 32'd1);
    checkOutput("coincident_idx", 32'(msg_index), 32'd1);

    // Reset in HOLD at idx2 returns straight to AUTO at idx0.
    doReset();
    idle(24);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    idle(5);
    checkOutput("pre_reset_idx", 32'(msg_index), 32'd2);
    checkOutput("pre_reset_paused", 32'(paused), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("midrun_reset_idx", 32'(msg_index), 32'd0);
    checkOutput("midrun_reset_bcd", 32'(bcd), 32'h0231);
    checkOutput("midrun_reset_paused", 32'(paused), 32'd0);
    checkOutput("midrun_reset_strobe", 32'(msg_strobe), 32'd0);

    // Random button traffic with occasional resets.
    for (int seg = 0; seg < 600; seg++) begin
      int len;
      bit r;
      n   = ($urandom_range(0, 2) == 0);
      p   = ($urandom_range(0, 5) == 0);
      len = $urandom_range(1, 7);
      r   = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < len; i++) applyStimulus(n, p, r && (i == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
